// File: rtl/cache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_pkg : address field map, line geometry and responder states |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package cache_pkg;

    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 11;
    localparam int IDX_MSB  = 10;
    localparam int IDX_LSB  = 4;
    localparam int WOFF_MSB = 3;
    localparam int WOFF_LSB = 2;
    localparam int BOFF_MSB = 1;
    localparam int BOFF_LSB = 0;
    localparam int WORD_NUM = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Critical-word-first order: the 2-bit sum wraps modulo the line size.
    function automatic logic [1:0] wrap_word(input logic [1:0] start, input logic [1:0] k);
        return start + k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_fill_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_fill_responder_if : cache <-> responder fill/writeback bus   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface line_fill_responder_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADR_WIDTH  = 32
);
    logic                  mem_req_i;
    logic [ADR_WIDTH-1:0]  mem_adr_i;
    logic                  mem_ack_o;
    logic [WORD_WIDTH-1:0] mem_dat_o;
    logic                  wb_valid_i;
    logic [ADR_WIDTH-1:0]  wb_adr_i;
    logic [1:0]            wb_word_i;
    logic [WORD_WIDTH-1:0] wb_dat_i;
    logic                  busy_o;

    modport master (
        output mem_req_i, mem_adr_i, wb_valid_i, wb_adr_i, wb_word_i, wb_dat_i,
        input  mem_ack_o, mem_dat_o, busy_o
    );

    modport slave (
        input  mem_req_i, mem_adr_i, wb_valid_i, wb_adr_i, wb_word_i, wb_dat_i,
        output mem_ack_o, mem_dat_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/line_fill_responder_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | resp_word_ram : 1R1W word store, registered read, read-before-write|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module resp_word_ram #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WORDS = 2048
) (
    input  wire logic                           clk,
    input  wire logic                           i_rd_en,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] i_rd_adr,
    output logic      [WORD_WIDTH-1:0]          o_rd_dat,
    input  wire logic                           i_wr_en,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] i_wr_adr,
    input  wire logic [WORD_WIDTH-1:0]          i_wr_dat
);
    // Power-up contents are zero; reset deliberately leaves the array alone.
    logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS] = '{default: '0};
    logic [WORD_WIDTH-1:0] r_rd_dat;

    // Both updates are non-blocking, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_adr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_adr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule
`default_nettype wire

// File: rtl/line_fill_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_fill_responder : critical-word-first line-fill memory model  |
// | Optional: LINE_FILL_RESPONDER_STALL_EN adds a gap after word 1.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module line_fill_responder
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int ADR_WIDTH   = 32,
    parameter int DEPTH_WORDS = 2048,
    parameter int LATENCY     = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    line_fill_responder_if.slave  bus
);
    localparam int         c_ram_aw   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

    state_t                r_state;
    logic [c_ram_aw-3:0]   r_line;
    logic [1:0]            r_start;
    logic [3:0]            r_cnt;
    logic [2:0]            r_k;
    logic                  r_ack;
    logic                  w_stall;
    logic                  w_issue;
    logic [c_ram_aw-1:0]   w_rd_adr;
    logic [c_ram_aw-1:0]   w_wr_adr;
    logic [WORD_WIDTH-1:0] w_rd_dat;
    logic                  w_unused_adr;

`ifdef LINE_FILL_RESPONDER_STALL_EN
    logic r_stalled;
    assign w_stall = (r_state == ST_BURST) && (r_k == 3'd2) && !r_stalled;
`else
    assign w_stall = 1'b0;
`endif

    // A word is fetched on the edge its ack rises: the last WAIT edge fetches k=0.
    assign w_issue  = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                      ((r_state == ST_BURST) && !r_k[2] && !w_stall);
    assign w_rd_adr = {r_line, wrap_word(r_start, r_k[1:0])};
    assign w_wr_adr = {bus.wb_adr_i[c_ram_aw+1:IDX_LSB], bus.wb_word_i};

    // Address bits beyond the backing store and the byte offsets carry no information here.
    assign w_unused_adr = ^{bus.mem_adr_i[ADR_WIDTH-1:c_ram_aw+2],
                            bus.mem_adr_i[BOFF_MSB:BOFF_LSB],
                            bus.wb_adr_i[ADR_WIDTH-1:c_ram_aw+2],
                            bus.wb_adr_i[WOFF_MSB:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_line  <= '0;
            r_start <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_ack   <= 1'b0;
`ifdef LINE_FILL_RESPONDER_STALL_EN
            r_stalled <= 1'b0;
`endif
        end else begin
            r_ack <= w_issue;
            if (w_issue) begin
                r_k <= r_k + 3'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req_i) begin
                        r_line  <= bus.mem_adr_i[c_ram_aw+1:IDX_LSB];
                        r_start <= bus.mem_adr_i[WOFF_MSB:WOFF_LSB];
                        r_cnt   <= c_lat_load;
                        r_k     <= '0;
`ifdef LINE_FILL_RESPONDER_STALL_EN
                        r_stalled <= 1'b0;
`endif
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_BURST;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_BURST: begin
                    // Stay busy while the last word is on the bus, then drop to IDLE.
                    if (r_k == 3'(WORD_NUM)) begin
                        r_state <= ST_IDLE;
                    end
`ifdef LINE_FILL_RESPONDER_STALL_EN
                    if (w_stall) begin
                        r_stalled <= 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    resp_word_ram #(
        .WORD_WIDTH  (WORD_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk      (clk),
        .i_rd_en  (w_issue),
        .i_rd_adr (w_rd_adr),
        .o_rd_dat (w_rd_dat),
        .i_wr_en  (bus.wb_valid_i),
        .i_wr_adr (w_wr_adr),
        .i_wr_dat (bus.wb_dat_i)
    );

    assign bus.mem_ack_o = r_ack;
    assign bus.mem_dat_o = r_ack ? w_rd_dat : '0;
    assign bus.busy_o    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
